// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the memory-access stage
//
// Package riscv_pkg:
//   XLEN           data/address width (32 only)
//   F3_*           load/store funct3 encodings
//   mem_state_t    memory-access FSM states
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} mem_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory request/grant/response bus
//
// master: the memory-access unit (drives request, write controls, address, data)
// slave : the data memory (drives grant, read-valid, read data)
interface mem_access_unit_if;

  logic                       dmem_req;
  logic                       dmem_we;
  logic [riscv_pkg::XLEN-1:0] dmem_addr;
  logic [riscv_pkg::XLEN-1:0] dmem_wdata;
  logic [3:0]                 dmem_wstrb;
  logic                       dmem_gnt;
  logic                       dmem_rvalid;
  logic [riscv_pkg::XLEN-1:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );

endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// rtl/mem_access_unit_load_formatter.sv - load data lane selection and extension
//
// Ports:
//   rdata   in   raw 32-bit word from data memory
//   funct3  in   load size/sign
//   offset  in   byte offset within the word
//   data    out  extended load result
module load_formatter
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    // Halfword lane uses only offset[1]; offset[0] is ignored.
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      F3_W:    data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RISC-V memory-access stage with bus FSM and pipeline stall
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN (adds misalign_o, suppresses
// misaligned accesses instead of truncating the low address bits).
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   valid_in .. regWrite_in         EX/MEM slot contents
//   dmem                            data-memory bus (master side)
//   mem_rd_data_out                 registered formatted load data
//   data_out                        ALU result pass-through
//   mem_rd_addr_out, memToReg_out,
//   regWrite_out                    writeback control pass-through
//   stall_o                         pipeline freeze while an access is in flight
//   misalign_o                      misaligned-access pulse (macro builds only)
module mem_access_unit
  import riscv_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in,
  input  logic [XLEN-1:0]      alu_result_in,
  input  logic [XLEN-1:0]      store_data_in,
  input  logic [2:0]           funct3_in,
  input  logic                 memRead_in,
  input  logic                 memWrite_in,
  input  logic [4:0]           rd_addr_in,
  input  logic                 memToReg_in,
  input  logic                 regWrite_in,
  mem_access_unit_if.master    dmem,
  output logic [XLEN-1:0]      mem_rd_data_out,
  output logic [XLEN-1:0]      data_out,
  output logic [4:0]           mem_rd_addr_out,
  output logic                 memToReg_out,
  output logic                 regWrite_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                 misalign_o,
`endif
  output logic                 stall_o
);

  mem_state_t      state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic [1:0]      b;
  logic            access;
  logic            misaligned;
  logic            go;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_wstrb;
  logic [XLEN-1:0] fmt_data;

  assign b      = alu_result_in[1:0];
  assign access = valid_in & (memRead_in | memWrite_in);

`ifdef MEM_MISALIGN_TRAP_EN
  always_comb begin
    misaligned = 1'b0;
    if (access) begin
      case (funct3_in)
        F3_B:    misaligned = 1'b0;
        F3_H:    misaligned = b[0];
        // Load-only encodings; as a store funct3 they fall back to SW.
        F3_BU:   misaligned = memWrite_in ? (b != 2'b00) : 1'b0;
        F3_HU:   misaligned = memWrite_in ? (b != 2'b00) : b[0];
        default: misaligned = (b != 2'b00);
      endcase
    end
  end
  assign misalign_o = misaligned & (state_q == IDLE);
`else
  assign misaligned = 1'b0;
`endif

  // A trapped access never reaches the bus and never stalls.
  assign go = access & ~misaligned;

  always_comb begin
    case (funct3_in)
      F3_B: begin
        st_wstrb = 4'b0001 << b;
        st_wdata = {4{store_data_in[7:0]}};
      end
      F3_H: begin
        st_wstrb = 4'b0011 << {b[1], 1'b0};
        st_wdata = {2{store_data_in[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = store_data_in;
      end
    endcase
  end

  load_formatter u_load_formatter (
    .rdata  (dmem.dmem_rdata),
    .funct3 (funct3_in),
    .offset (b),
    .data   (fmt_data)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          req_d   = 1'b1;
          we_d    = memWrite_in;
          addr_d  = {alu_result_in[XLEN-1:2], 2'b00};
          wdata_d = st_wdata;
          wstrb_d = memWrite_in ? st_wstrb : 4'b0000;
          state_d = REQ;
        end
      end
      REQ: begin
        if (dmem.dmem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (dmem.dmem_rvalid) begin
          rd_data_d = fmt_data;
          state_d   = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= 4'b0000;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign mem_rd_data_out = rd_data_q;
  assign data_out        = alu_result_in;
  assign mem_rd_addr_out = rd_addr_in;
  assign memToReg_out    = memToReg_in;
  assign regWrite_out    = regWrite_in & ~misaligned;
  // DONE releases the stall so MEM/WB captures on this edge.
  assign stall_o         = go & (state_q != DONE);

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [2:0]  funct3_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic [4:0]  rd_addr_in;
  logic        memToReg_in;
  logic        regWrite_in;
  logic [31:0] mem_rd_data_out;
  logic [31:0] data_out;
  logic [4:0]  mem_rd_addr_out;
  logic        memToReg_out;
  logic        regWrite_out;
  logic        stall_o;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_unit_if dmem_bus ();

  mem_access_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .valid_in        (valid_in),
    .alu_result_in   (alu_result_in),
    .store_data_in   (store_data_in),
    .funct3_in       (funct3_in),
    .memRead_in      (memRead_in),
    .memWrite_in     (memWrite_in),
    .rd_addr_in      (rd_addr_in),
    .memToReg_in     (memToReg_in),
    .regWrite_in     (regWrite_in),
    .dmem            (dmem_bus),
    .mem_rd_data_out (mem_rd_data_out),
    .data_out        (data_out),
    .mem_rd_addr_out (mem_rd_addr_out),
    .memToReg_out    (memToReg_out),
    .regWrite_out    (regWrite_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_o      (misalign_o),
`endif
    .stall_o         (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata);
    valid_in      = v;
    memRead_in    = rd;
    memWrite_in   = wr;
    funct3_in     = f3;
    alu_result_in = addr;
    store_data_in = sdata;
    rd_addr_in    = 5'd7;
    memToReg_in   = rd;
    regWrite_in   = ~wr;
  endtask

  // Acts as the memory: grants after gnt_dly request cycles, returns rvalid the
  // cycle after a read grant. Returns at the DONE cycle (first non-stall cycle).
  task automatic run_access(input int gnt_dly, input bit spurious, input logic [31:0] rdata,
                            output int stalls, output logic [31:0] addr,
                            output logic [31:0] wdata, output logic [3:0] wstrb);
    int  req_cyc = 0;
    bit  rd_pend = 0;
    int  guard   = 0;
    stalls = 0; addr = 'x; wdata = 'x; wstrb = 'x;
    while (guard < 40) begin
      #1;
      dmem_bus.dmem_gnt    = 1'b0;
      dmem_bus.dmem_rvalid = 1'b0;
      dmem_bus.dmem_rdata  = 32'h0;
      if (!stall_o) break;
      stalls++;
      if (rd_pend) begin
        dmem_bus.dmem_rvalid = 1'b1;
        dmem_bus.dmem_rdata  = rdata;
        rd_pend = 0;
      end else if (dmem_bus.dmem_req) begin
        addr  = dmem_bus.dmem_addr;
        wdata = dmem_bus.dmem_wdata;
        wstrb = dmem_bus.dmem_wstrb;
        if (req_cyc >= gnt_dly) begin
          dmem_bus.dmem_gnt = 1'b1;
          if (!dmem_bus.dmem_we) rd_pend = 1;
          if (spurious) begin
            dmem_bus.dmem_rvalid = 1'b1;
            dmem_bus.dmem_rdata  = 32'hDEAD_BEEF;
          end
        end
        req_cyc++;
      end
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check("access_timeout", 32'(guard), 32'd0);
  endtask

  int          st;
  logic [31:0] a, wd;
  logic [3:0]  ws;

  initial begin
    rst_n = 1'b0;
    set_instr(0, 0, 0, 3'b000, 32'h0, 32'h0);
    dmem_bus.dmem_gnt    = 1'b0;
    dmem_bus.dmem_rvalid = 1'b0;
    dmem_bus.dmem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'h0, dmem_bus.dmem_req}, 32'h0);
    check("rst_we",    {31'h0, dmem_bus.dmem_we},  32'h0);
    check("rst_addr",  dmem_bus.dmem_addr,  32'h0);
    check("rst_wdata", dmem_bus.dmem_wdata, 32'h0);
    check("rst_wstrb", {28'h0, dmem_bus.dmem_wstrb}, 32'h0);
    check("rst_rdout", mem_rd_data_out, 32'h0);
    check("rst_stall", {31'h0, stall_o}, 32'h0);
    rst_n = 1'b1;

    // ALU op passes through with no stall
    @(negedge clk);
    set_instr(1, 0, 0, 3'b000, 32'h1234, 32'h0);
    #1;
    check("alu_data",  data_out, 32'h1234);
    check("alu_stall", {31'h0, stall_o}, 32'h0);
    check("alu_rd",    {27'h0, mem_rd_addr_out}, 32'd7);
    check("alu_rw",    {31'h0, regWrite_out}, 32'h1);
    @(negedge clk);
    check("alu_noreq", {31'h0, dmem_bus.dmem_req}, 32'h0);

    // LB at 0x103, immediate gnt/rvalid
    set_instr(1, 1, 0, 3'b000, 32'h103, 32'h0);
    run_access(0, 0, 32'h80FF_FF00, st, a, wd, ws);
    check("lb_stalls", 32'(st), 32'd3);
    check("lb_addr",   a, 32'h100);
    check("lb_data",   mem_rd_data_out, 32'hFFFF_FF80);

    // SH at 0x202, gnt withheld 2 cycles
    @(negedge clk);
    set_instr(1, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD);
    run_access(2, 0, 32'h0, st, a, wd, ws);
    check("sh_stalls", 32'(st), 32'd4);
    check("sh_addr",   a, 32'h200);
    check("sh_wdata",  wd, 32'hABCD_ABCD);
    check("sh_wstrb",  {28'h0, ws}, 32'hC);
    check("sh_rw",     {31'h0, regWrite_out}, 32'h0);

    // LHU at 0x002
    @(negedge clk);
    set_instr(1, 1, 0, 3'b101, 32'h002, 32'h0);
    run_access(0, 0, 32'h8001_0000, st, a, wd, ws);
    check("lhu_stalls", 32'(st), 32'd3);
    check("lhu_data",   mem_rd_data_out, 32'h0000_8001);

    // LW with spurious rvalid during REQ
    @(negedge clk);
    set_instr(1, 1, 0, 3'b010, 32'h040, 32'h0);
    run_access(0, 1, 32'h1234_5678, st, a, wd, ws);
    check("lw_stalls", 32'(st), 32'd3);
    check("lw_data",   mem_rd_data_out, 32'h1234_5678);

    // SB at 0x011, immediate gnt
    @(negedge clk);
    set_instr(1, 0, 1, 3'b000, 32'h011, 32'h0000_005A);
    run_access(0, 0, 32'h0, st, a, wd, ws);
    check("sb_stalls", 32'(st), 32'd2);
    check("sb_addr",   a, 32'h010);
    check("sb_wdata",  wd, 32'h5A5A_5A5A);
    check("sb_wstrb",  {28'h0, ws}, 32'h2);

    // SW at 0x020
    @(negedge clk);
    set_instr(1, 0, 1, 3'b010, 32'h020, 32'hCAFE_0001);
    run_access(1, 0, 32'h0, st, a, wd, ws);
    check("sw_stalls", 32'(st), 32'd3);
    check("sw_wdata",  wd, 32'hCAFE_0001);
    check("sw_wstrb",  {28'h0, ws}, 32'hF);

    // LH at 0x004 (lower half, negative)
    @(negedge clk);
    set_instr(1, 1, 0, 3'b001, 32'h004, 32'h0);
    run_access(0, 0, 32'h0000_F234, st, a, wd, ws);
    check("lh_data", mem_rd_data_out, 32'hFFFF_F234);

    // LBU at 0x101
    @(negedge clk);
    set_instr(1, 1, 0, 3'b100, 32'h101, 32'h0);
    run_access(0, 0, 32'h0000_9A00, st, a, wd, ws);
    check("lbu_data", mem_rd_data_out, 32'h0000_009A);

    // Load data holds across a non-memory instruction
    @(negedge clk);
    set_instr(1, 0, 0, 3'b000, 32'h55, 32'h0);
    @(negedge clk);
    check("hold_data", mem_rd_data_out, 32'h0000_009A);

    // Reset during REQ: request drops with rst_n
    set_instr(1, 1, 0, 3'b010, 32'h300, 32'h0);
    #1;
    check("rq_stall", {31'h0, stall_o}, 32'h1);
    @(negedge clk);
    check("rq_req_hi", {31'h0, dmem_bus.dmem_req}, 32'h1);
    rst_n = 1'b0;
    set_instr(0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    check("rq_req_lo", {31'h0, dmem_bus.dmem_req}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WAIT
    set_instr(1, 1, 0, 3'b010, 32'h304, 32'h0);
    @(negedge clk);
    dmem_bus.dmem_gnt = 1'b1;
    @(negedge clk);
    dmem_bus.dmem_gnt = 1'b0;
    rst_n = 1'b0;
    set_instr(0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    check("rw_req",    {31'h0, dmem_bus.dmem_req}, 32'h0);
    check("rw_rdout",  mem_rd_data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rw_stall",  {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    check("rw_idle_req", {31'h0, dmem_bus.dmem_req}, 32'h0);

    // Fresh load after reset takes the full IDLE path
    set_instr(1, 1, 0, 3'b010, 32'h010, 32'h0);
    run_access(0, 0, 32'hCAFE_F00D, st, a, wd, ws);
    check("post_stalls", 32'(st), 32'd3);
    check("post_data",   mem_rd_data_out, 32'hCAFE_F00D);

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    set_instr(1, 1, 0, 3'b010, 32'h101, 32'h0);
    #1;
    check("mis_pulse", {31'h0, misalign_o}, 32'h1);
    check("mis_rw",    {31'h0, regWrite_out}, 32'h0);
    check("mis_stall", {31'h0, stall_o}, 32'h0);
    @(negedge clk);
    set_instr(0, 0, 0, 3'b000, 32'h0, 32'h0);
    #1;
    check("mis_noreq", {31'h0, dmem_bus.dmem_req}, 32'h0);
    check("mis_end",   {31'h0, misalign_o}, 32'h0);
`endif

    @(negedge clk);
    set_instr(0, 0, 0, 3'b000, 32'h0, 32'h0);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-access stage of the RISC-V pipeline, between the EX/MEM and MEM/WB registers. Turns EX/MEM load/store controls into a request/grant/response transaction on the data-memory bus. Formats load data: byte/halfword extraction with sign or zero extension. Stalls the pipeline until the access completes. Non-memory instructions pass straight through to MEM/WB with no added latency.

## Interface
- XLEN, 32, data and address width; only 32 is supported.
- clk  in  1  pipeline clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- valid_in  in  1  the EX/MEM slot holds a live instruction.
- alu_result_in  in  XLEN  effective address for loads/stores; the result for other instructions.
- store_data_in  in  XLEN  rs2 value for stores.
- funct3_in  in  3  access size and sign.
- memRead_in / memWrite_in  in  1 each  load / store.
- rd_addr_in  in  5  destination register.
- memToReg_in / regWrite_in  in  1 each  writeback controls.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 means write.
- dmem_addr  out  XLEN  word-aligned address, bits [1:0] = 0.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_wstrb  out  4  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.
- mem_rd_data_out  out  XLEN  formatted load data, to MEM/WB.
- data_out  out  XLEN  combinational copy of alu_result_in.
- mem_rd_addr_out, memToReg_out, regWrite_out  out  5/1/1  pass-through to MEM/WB.
- stall_o  out  1  freezes PC, IF/ID, ID/EX, EX/MEM and the MEM/WB load.
- misalign_o  out  1  misaligned-access flag; present only with the configuration macro defined.

## Operation
- The FSM has four states: IDLE, REQ, WAIT, DONE.
- An access is valid_in & (memRead_in | memWrite_in). memRead_in and memWrite_in are never both set.
- IDLE:
  - If an access is present, latch the bus address, we, wdata and wstrb, then go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dmem_req = 1; dmem_we, dmem_addr, dmem_wdata and dmem_wstrb hold stable.
  - On dmem_gnt, a store goes to DONE and a load goes to WAIT.
- WAIT:
  - On dmem_rvalid, capture the formatted data into mem_rd_data_out and go to DONE.
  - dmem_rvalid is ignored in every other state; dmem_gnt is ignored outside REQ.
- DONE: stall_o = 0, so MEM/WB latches on this edge; then go to IDLE.
- stall_o = access present & state != DONE. It is combinational and is asserted in the same cycle an access appears.
- Load formatting uses byte offset b = alu_result_in[1:0]:
  - LB (000) and LBU (100): byte b, sign- or zero-extended.
  - LH (001) and LHU (101): halfword b[1], sign- or zero-extended.
  - LW (010): the full word.
  - Load funct3 011, 110 and 111 are treated as LW.
- Store encoding:
  - SB: wstrb = 0001 << b, wdata = byte replicated into all four lanes.
  - SH: wstrb = 0011 << (2·b[1]), wdata = halfword replicated into both halves.
  - SW: wstrb = 1111. Any other store funct3 is treated as SW.
- Reset values: state IDLE; dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, mem_rd_data_out and misalign_o are all 0. Pass-through outputs follow their inputs.
- Reset asserted mid-transaction abandons it immediately: dmem_req falls with rst_n.

## Timing
- Non-memory instruction: 0 added cycles, stall_o = 0.
- Load with gnt and rvalid each arriving in the first possible cycle: 3 stall cycles (IDLE, REQ, WAIT), then DONE.
- Store with immediate gnt: 2 stall cycles (IDLE, REQ), then DONE.
- Each cycle gnt or rvalid is withheld adds exactly one stall cycle. There is no timeout.
- mem_rd_data_out is registered and stays valid from DONE until the next load's capture.

## Configuration
- MEM_MISALIGN_TRAP_EN defined:
  - A misaligned access is LH/LHU/SH with b[0] = 1, or LW/SW with b ≠ 0.
  - It issues no bus request, pulses misalign_o for one cycle in IDLE, forces regWrite_out to 0, and never stalls.
- MEM_MISALIGN_TRAP_EN undefined: the misalign_o port is absent; offending low address bits are ignored (a halfword uses b[1] only, a word uses b = 0).

## Structure
- Package riscv_pkg holds:
  - XLEN;
  - the funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the typedef mem_state_t enum {IDLE, REQ, WAIT, DONE}.
- Sub-module load_formatter: combinational (rdata, funct3, offset) -> extended data. It is instantiated once.

## Test plan
- ALU op, alu_result_in = 0x1234 -> data_out = 0x1234 the same cycle; stall_o = 0; dmem_req never asserted.
- LB at 0x103, rdata = 0x80FF_FF00, gnt and rvalid immediate -> stall_o high for exactly 3 cycles; mem_rd_data_out = 0xFFFF_FF80; dmem_addr = 0x100.
- SH at 0x202, data 0xABCD, gnt withheld 2 cycles -> dmem_wstrb = 1100, dmem_wdata = 0xABCD_ABCD, dmem_addr = 0x200; 4 stall cycles.
- LHU at 0x002, rdata = 0x8001_0000 -> 0x0000_8001. LW with a spurious rvalid during REQ -> ignored; data captured only in WAIT.
- rst_n low while in WAIT -> dmem_req = 0, state IDLE, stall_o = 0 on release with no access present.
- With MEM_MISALIGN_TRAP_EN, LW at 0x101 -> misalign_o one-cycle pulse, regWrite_out = 0, no dmem_req, stall_o = 0.
